wor_irq_capture: RTL and testbench
==================================

# wor_irq_capture

Capture stage for a wired-OR interrupt line. Several sources drive one `wor` net; this block consumes the resolved net asynchronously. It synchronizes and glitch-filters the line, then converts each filtered rising edge into a sticky `pending` flag plus a saturating event count. Software or a downstream controller clears the flag and count with a one-cycle acknowledge.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count, legal range ≥2.
- `FILT_LEN`, default 4: consecutive agreeing samples required to change the filtered level, legal range ≥1.
- `CNT_W`, default 8: event counter width, legal range ≥1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low, synchronously released by the system.
- `irq_wor`  in  1  resolved wired-OR interrupt net; asynchronous to `clk`.
- `enable`  in  1  when 0, edges are tracked but not recorded.
- `ack`  in  1  single-cycle clear strobe for `pending`, `event_cnt` and `overflow`.
- `irq_level`  out  1  filtered, synchronized line level.
- `pending`  out  1  sticky: a filtered rising edge was seen since the last `ack`.
- `event_cnt`  out  CNT_W  count of recorded rising edges since the last `ack`; saturating.
- `overflow`  out  1  sticky: a rising edge occurred while `event_cnt` was at its maximum.

## Operation
- Synchronizer: a chain of SYNC_STAGES flops samples `irq_wor`. The last stage is `sync_q`.
- Filter FSM, evaluated on each edge:
  - States: LOW, RISE_CHK, HIGH, FALL_CHK. A counter `fcnt` runs 0..FILT_LEN-1.
  - LOW: if `sync_q`=1, go to RISE_CHK with `fcnt`=1. If FILT_LEN=1, go directly to HIGH instead.
  - RISE_CHK:
    - `sync_q`=0: return to LOW and clear `fcnt`.
    - `sync_q`=1 and `fcnt`=FILT_LEN-1: go to HIGH.
    - Otherwise increment `fcnt`.
  - HIGH and FALL_CHK mirror LOW and RISE_CHK with the polarity inverted.
  - `irq_level` = 1 in HIGH and FALL_CHK, 0 in LOW and RISE_CHK. It is registered from the state.
- Rise event: the clock edge on which the FSM moves RISE_CHK→HIGH, or LOW→HIGH when FILT_LEN=1.
- Recording, on a rise event with `enable`=1:
  - `pending` ← 1.
  - `event_cnt` ← `event_cnt`+1 if `event_cnt` < 2^CNT_W−1.
  - Otherwise `event_cnt` holds and `overflow` ← 1.
- `ack`=1 clears `pending`, `event_cnt` and `overflow` to 0.
- `ack` coinciding with a recorded rise event: the event wins over the clear. Result is `pending`=1, `event_cnt`=1, `overflow`=0.
- `enable`=0:
  - The filter FSM and `irq_level` keep running.
  - Rise events are discarded, never deferred.
  - `ack` still clears.
- Falling edges are never recorded.

## Timing
- Reset (`rst_n`=0), effective immediately and asynchronously:
  - All synchronizer flops 0, FSM = LOW, `fcnt`=0.
  - `irq_level`=0, `pending`=0, `event_cnt`=0, `overflow`=0.
- Reset mid-operation discards any partial filter count and recorded events. After release, a line already high is re-detected as a new rise.
- Latency: count the first rising edge at which `irq_wor`=1 is sampled as edge 1. `irq_level`, `pending` and `event_cnt` update together on edge SYNC_STAGES+FILT_LEN. With defaults this is edge 6.
- Fall latency to `irq_level`=0 is the same: SYNC_STAGES+FILT_LEN edges.
- Glitch rejection: a pulse of fewer than FILT_LEN consecutive `sync_q` samples produces no level change and no event.
- `ack` takes effect on the edge that samples it. The cleared outputs are visible in the following cycle.
- Minimum spacing for distinct events: FILT_LEN high samples plus FILT_LEN low samples, i.e. 2·FILT_LEN cycles.
- `irq_wor` is driven only 0/1 by benches. X/Z resolution is the net's concern, not this block's.

## Test plan
- Basic rise, defaults, `enable`=1: raise `irq_wor` and hold for 10 cycles → `irq_level`, `pending`=1 and `event_cnt`=1 on edge 6. Drop the line → `irq_level`=0 six edges later; `pending` stays 1.
- Glitch: a 3-cycle high pulse → `irq_level`, `pending` and `event_cnt` stay 0. A 4-cycle pulse → exactly one event.
- Saturation with `CNT_W`=2: five separate filtered pulses → `event_cnt`=3, `overflow`=1 after the 4th pulse. `ack` → all outputs 0 next cycle.
- `ack` collision: assert `ack` on the same edge as a rise event while `event_cnt`=2 → `pending`=1, `event_cnt`=1, `overflow`=0.
- `enable`=0 during a rise → `irq_level` goes to 1 and `pending`/`event_cnt` stay 0. Setting `enable`=1 afterwards while the line is still high → still no event.
- Async reset at edge 4 of a rise → all outputs 0 immediately. Release `rst_n` with the line still high → one event recorded 6 edges after release.

Source files
------------

// File: rtl/wor_irq_capture.sv
// wor_irq_capture: synchronize and glitch-filter a wired-OR interrupt
// net, then record filtered rising edges as a pending flag and count.
module wor_irq_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_wor,
    input  logic             enable,
    input  logic             ack,
    output logic             irq_level,
    output logic             pending,
    output logic [CNT_W-1:0] event_cnt,
    output logic             overflow
);

    typedef enum logic [1:0] {
        LOW,
        RISE_CHK,
        HIGH,
        FALL_CHK
    } filt_state_t;

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILT_LEN - 1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit   FILT_BYPASS = (FILT_LEN == 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    filt_state_t            state_q;
    logic [FW-1:0]          fcnt_q;
    logic                   rise_evt;
    logic                   record;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Shift the asynchronous net through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], irq_wor};
        end
    end

    // Decode the edge on which the filter commits to HIGH
    always_comb begin
        rise_evt = 1'b0;
        if (sync_q) begin
            if (state_q == RISE_CHK && fcnt_q == FCNT_LAST) begin
                rise_evt = 1'b1;
            end
            if (FILT_BYPASS && state_q == LOW) begin
                rise_evt = 1'b1;
            end
        end
    end

    assign record = rise_evt & enable;

    // Filter FSM; level output registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOW;
            fcnt_q    <= '0;
            irq_level <= 1'b0;
        end else begin
            unique case (state_q)
                LOW: begin
                    if (sync_q) begin
                        if (FILT_BYPASS) begin
                            state_q   <= HIGH;
                            irq_level <= 1'b1;
                        end else begin
                            state_q <= RISE_CHK;
                            fcnt_q  <= FCNT_ONE;
                        end
                    end
                end
                RISE_CHK: begin
                    if (!sync_q) begin
                        state_q <= LOW;
                        fcnt_q  <= '0;
                    end else if (fcnt_q == FCNT_LAST) begin
                        state_q   <= HIGH;
                        fcnt_q    <= '0;
                        irq_level <= 1'b1;
                    end else begin
                        fcnt_q <= fcnt_q + FCNT_ONE;
                    end
                end
                HIGH: begin
                    if (!sync_q) begin
                        if (FILT_BYPASS) begin
                            state_q   <= LOW;
                            irq_level <= 1'b0;
                        end else begin
                            state_q <= FALL_CHK;
                            fcnt_q  <= FCNT_ONE;
                        end
                    end
                end
                FALL_CHK: begin
                    if (sync_q) begin
                        state_q <= HIGH;
                        fcnt_q  <= '0;
                    end else if (fcnt_q == FCNT_LAST) begin
                        state_q   <= LOW;
                        fcnt_q    <= '0;
                        irq_level <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q + FCNT_ONE;
                    end
                end
                default: begin
                    state_q   <= LOW;
                    fcnt_q    <= '0;
                    irq_level <= 1'b0;
                end
            endcase
        end
    end

    // Record enabled rise events; an event beats a coincident ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            event_cnt <= '0;
            overflow  <= 1'b0;
        end else if (record) begin
            pending <= 1'b1;
            if (ack) begin
                event_cnt <= CNT_ONE;
                overflow  <= 1'b0;
            end else if (event_cnt != CNT_MAX) begin
                event_cnt <= event_cnt + CNT_ONE;
            end else begin
                overflow <= 1'b1;
            end
        end else if (ack) begin
            pending   <= 1'b0;
            event_cnt <= '0;
            overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wor_irq_capture.sv
// tb_wor_irq_capture: directed checks of filtering, recording,
// saturation, ack collision, enable gating and async reset.
module tb_wor_irq_capture;

    logic       clk;
    logic       rst_n;
    logic       irq_wor;
    logic       enable;
    logic       ack;

    logic       lvl8;
    logic       pnd8;
    logic [7:0] cnt8;
    logic       ovf8;

    logic       lvl2;
    logic       pnd2;
    logic [1:0] cnt2;
    logic       ovf2;

    logic       lvl1;
    logic       pnd1;
    logic [7:0] cnt1;
    logic       ovf1;

    int checks;
    int errors;

    wor_irq_capture #(.SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .irq_wor(irq_wor),
        .enable(enable), .ack(ack), .irq_level(lvl8),
        .pending(pnd8), .event_cnt(cnt8), .overflow(ovf8)
    );

    wor_irq_capture #(.SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .irq_wor(irq_wor),
        .enable(enable), .ack(ack), .irq_level(lvl2),
        .pending(pnd2), .event_cnt(cnt2), .overflow(ovf2)
    );

    wor_irq_capture #(.SYNC_STAGES(2), .FILT_LEN(1), .CNT_W(8)) dut_f1 (
        .clk(clk), .rst_n(rst_n), .irq_wor(irq_wor),
        .enable(enable), .ack(ack), .irq_level(lvl1),
        .pending(pnd1), .event_cnt(cnt1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic pulse();
        irq_wor = 1'b1;
        tick(6);
        irq_wor = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        irq_wor = 1'b0;
        enable = 1'b1;
        ack = 1'b0;
        tick(3);
        checks++;
        if ({lvl8, pnd8, cnt8, ovf8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0",
                     {lvl8, pnd8, cnt8, ovf8});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic_rise();
        irq_wor = 1'b1;
        tick(3);
        checks++;
        if (lvl1 !== 1'b1) begin
            errors++;
            $display("FAIL f1_rise_edge3: got %b expected 1", lvl1);
        end
        tick(2);
        checks++;
        if (lvl8 !== 1'b0 || pnd8 !== 1'b0) begin
            errors++;
            $display("FAIL rise_edge5: got lvl=%b pnd=%b expected 0 0",
                     lvl8, pnd8);
        end
        tick(1);
        checks++;
        if (lvl8 !== 1'b1 || pnd8 !== 1'b1 || cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL rise_edge6: got lvl=%b pnd=%b cnt=%0d expected 1 1 1",
                     lvl8, pnd8, cnt8);
        end
        tick(4);
        irq_wor = 1'b0;
        tick(5);
        checks++;
        if (lvl8 !== 1'b1) begin
            errors++;
            $display("FAIL fall_edge5: got lvl=%b expected 1", lvl8);
        end
        tick(1);
        checks++;
        if (lvl8 !== 1'b0 || pnd8 !== 1'b1 || cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL fall_edge6: got lvl=%b pnd=%b cnt=%0d expected 0 1 1",
                     lvl8, pnd8, cnt8);
        end
        do_ack();
        checks++;
        if (pnd8 !== 1'b0 || cnt8 !== 8'd0 || pnd1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: got pnd=%b cnt=%0d pnd1=%b expected 0 0 0",
                     pnd8, cnt8, pnd1);
        end
    endtask

    task automatic test_glitch();
        irq_wor = 1'b1;
        tick(3);
        irq_wor = 1'b0;
        tick(10);
        checks++;
        if (lvl8 !== 1'b0 || pnd8 !== 1'b0 || cnt8 !== 8'd0) begin
            errors++;
            $display("FAIL glitch3: got lvl=%b pnd=%b cnt=%0d expected 0 0 0",
                     lvl8, pnd8, cnt8);
        end
        irq_wor = 1'b1;
        tick(4);
        irq_wor = 1'b0;
        tick(2);
        checks++;
        if (lvl8 !== 1'b1 || pnd8 !== 1'b1 || cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL glitch4: got lvl=%b pnd=%b cnt=%0d expected 1 1 1",
                     lvl8, pnd8, cnt8);
        end
        tick(10);
        do_ack();
    endtask

    task automatic test_saturation();
        pulse();
        pulse();
        pulse();
        checks++;
        if (cnt2 !== 2'd3 || ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_3: got cnt=%0d ovf=%b expected 3 0",
                     cnt2, ovf2);
        end
        pulse();
        checks++;
        if (cnt2 !== 2'd3 || ovf2 !== 1'b1 || pnd2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_4: got cnt=%0d ovf=%b pnd=%b expected 3 1 1",
                     cnt2, ovf2, pnd2);
        end
        pulse();
        checks++;
        if (cnt2 !== 2'd3 || ovf2 !== 1'b1 || cnt8 !== 8'd5 ||
            ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL sat_5: got cnt2=%0d ovf2=%b cnt8=%0d ovf8=%b expected 3 1 5 0",
                     cnt2, ovf2, cnt8, ovf8);
        end
        do_ack();
        checks++;
        if ({lvl2, pnd2, cnt2, ovf2} !== 5'd0) begin
            errors++;
            $display("FAIL sat_ack: got %b expected 0",
                     {lvl2, pnd2, cnt2, ovf2});
        end
    endtask

    task automatic test_ack_collision();
        pulse();
        pulse();
        checks++;
        if (cnt2 !== 2'd2) begin
            errors++;
            $display("FAIL coll_pre: got cnt=%0d expected 2", cnt2);
        end
        irq_wor = 1'b1;
        tick(5);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++;
        if (pnd2 !== 1'b1 || cnt2 !== 2'd1 || ovf2 !== 1'b0 ||
            cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL ack_collision: got pnd=%b cnt=%0d ovf=%b cnt8=%0d expected 1 1 0 1",
                     pnd2, cnt2, ovf2, cnt8);
        end
        irq_wor = 1'b0;
        tick(8);
        do_ack();
    endtask

    task automatic test_enable_gate();
        enable = 1'b0;
        irq_wor = 1'b1;
        tick(6);
        checks++;
        if (lvl8 !== 1'b1 || pnd8 !== 1'b0 || cnt8 !== 8'd0) begin
            errors++;
            $display("FAIL en0_rise: got lvl=%b pnd=%b cnt=%0d expected 1 0 0",
                     lvl8, pnd8, cnt8);
        end
        enable = 1'b1;
        tick(4);
        checks++;
        if (pnd8 !== 1'b0 || cnt8 !== 8'd0) begin
            errors++;
            $display("FAIL en1_no_defer: got pnd=%b cnt=%0d expected 0 0",
                     pnd8, cnt8);
        end
        irq_wor = 1'b0;
        tick(8);
        checks++;
        if (lvl8 !== 1'b0 || pnd8 !== 1'b0) begin
            errors++;
            $display("FAIL en_fall: got lvl=%b pnd=%b expected 0 0",
                     lvl8, pnd8);
        end
    endtask

    task automatic test_async_reset();
        pulse();
        irq_wor = 1'b1;
        tick(3);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lvl8, pnd8, cnt8, ovf8} !== 11'd0 || pnd2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %b pnd2=%b expected 0 0",
                     {lvl8, pnd8, cnt8, ovf8}, pnd2);
        end
        tick(2);
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (pnd8 !== 1'b0 || lvl8 !== 1'b0) begin
            errors++;
            $display("FAIL rel_edge5: got lvl=%b pnd=%b expected 0 0",
                     lvl8, pnd8);
        end
        tick(1);
        checks++;
        if (lvl8 !== 1'b1 || pnd8 !== 1'b1 || cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL rel_edge6: got lvl=%b pnd=%b cnt=%0d expected 1 1 1",
                     lvl8, pnd8, cnt8);
        end
        irq_wor = 1'b0;
        tick(8);
        do_ack();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_rise();
        test_glitch();
        test_saturation();
        test_ack_collision();
        test_enable_gate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
